// File: rtl/video_timing_detect_if.sv
// Sync stream produced by the video signal generator: hsync, vsync and data enable.
interface video_timing_detect_if;
    logic hsync;
    logic vsync;
    logic video_enable;

    modport master (output hsync, output vsync, output video_enable);
    modport slave  (input  hsync, input  vsync, input  video_enable);
endinterface

// File: rtl/video_timing_detect.sv
// Pixel-domain sync/DE receiver: recovers sx/sy and start pulses, measures timing and declares lock.
// Define VIDEO_DETECT_ERRCNT_EN to add the err_count port (saturating lock-loss counter).
module video_timing_detect #(
    parameter int unsigned HRES        = 640,
    parameter int unsigned VRES        = 480,
    parameter int unsigned COORDSPC    = 16,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned LOCK_FRAMES = 3,
    parameter int unsigned TIMEOUT     = 2000000
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    video_timing_detect_if.slave  vid,
    output logic                  de_out,
    output logic [COORDSPC-1:0]   sx,
    output logic [COORDSPC-1:0]   sy,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [COORDSPC-1:0]   h_active,
    output logic [COORDSPC-1:0]   h_total,
    output logic [COORDSPC-1:0]   v_active,
    output logic [COORDSPC-1:0]   v_total,
    output logic                  locked,
`ifdef VIDEO_DETECT_ERRCNT_EN
    output logic [15:0]           err_count,
`endif
    output logic                  res_match
);
    localparam logic [COORDSPC-1:0] CMAX = '1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned MW = $clog2(LOCK_FRAMES + 2);

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_CHECK, S_LOCKED} state_t;

    function automatic logic [COORDSPC-1:0] sat_inc(input logic [COORDSPC-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_p_q;
    logic hs_d, vs_d, de_d;
    logic de_rise, de_fall, hs_edge, vs_edge;

    logic [COORDSPC-1:0] pix_cnt_q, pix_cnt_d, hclk_q, hclk_d, hs_cnt_q, hs_cnt_d;
    logic [COORDSPC-1:0] sx_q, sx_d, sy_q, sy_d, sy_line, hs_line;
    logic [COORDSPC-1:0] h_active_q, h_active_d, h_total_q, h_total_d;
    logic [COORDSPC-1:0] v_active_q, v_active_d, v_total_q, v_total_d;
    logic                seen_rise_q, seen_rise_d, fs_pend_q, fs_pend_d;
    logic                de_out_q, de_out_d, line_start_q, line_start_d;
    logic                frame_start_q, frame_start_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;

    state_t              state_q;
    logic [MW-1:0]       match_cnt_q;
    logic [COORDSPC-1:0] ref_ha_q, ref_ht_q, ref_va_q, ref_vt_q;
    logic                locked_q, res_match_q;
    logic                timeout, meas_sat, frame_eq, line_bad, res_ok, lock_hit;
`ifdef VIDEO_DETECT_ERRCNT_EN
    logic [15:0]         err_cnt_q;
`endif

    always_comb begin
        // Syncs normalised so that 1 always means "in sync pulse".
        hs_d = (vid.hsync == SYNC_ACTIVE);
        vs_d = (vid.vsync == SYNC_ACTIVE);
        de_d = vid.video_enable;

        de_rise = de_q & ~de_p_q;
        de_fall = ~de_q & de_p_q;
        hs_edge = hs_q & ~hs_p_q;
        vs_edge = vs_q & ~vs_p_q;

        pix_cnt_d = pix_cnt_q;
        sx_d      = sx_q;
        if (de_rise) begin
            pix_cnt_d = {{(COORDSPC-1){1'b0}}, 1'b1};
            sx_d      = '0;
        end else if (de_q) begin
            pix_cnt_d = sat_inc(pix_cnt_q);
            sx_d      = sat_inc(sx_q);
        end

        hclk_d      = de_rise ? {{(COORDSPC-1){1'b0}}, 1'b1} : sat_inc(hclk_q);
        h_total_d   = (de_rise && seen_rise_q) ? hclk_q : h_total_q;
        seen_rise_d = seen_rise_q | de_rise;
        h_active_d  = de_fall ? pix_cnt_q : h_active_q;

        // A line ending in the same cycle as vsync is counted into the closing frame.
        sy_line    = de_fall ? sat_inc(sy_q) : sy_q;
        hs_line    = hs_edge ? sat_inc(hs_cnt_q) : hs_cnt_q;
        sy_d       = vs_edge ? '0 : sy_line;
        hs_cnt_d   = vs_edge ? '0 : hs_line;
        v_active_d = vs_edge ? sy_line : v_active_q;
        v_total_d  = vs_edge ? hs_line : v_total_q;

        fs_pend_d     = vs_edge ? 1'b1 : (de_rise ? 1'b0 : fs_pend_q);
        frame_start_d = de_rise & fs_pend_q;
        line_start_d  = de_rise;
        de_out_d      = de_q;

        to_cnt_d = vs_edge ? '0 : ((to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1);
        timeout  = !vs_edge && (to_cnt_q == TW'(TIMEOUT - 1));

        meas_sat = (h_active_d == CMAX) || (h_total_d == CMAX) ||
                   (v_active_d == CMAX) || (v_total_d == CMAX);
        frame_eq = !meas_sat && (h_active_d == ref_ha_q) && (h_total_d == ref_ht_q) &&
                   (v_active_d == ref_va_q) && (v_total_d == ref_vt_q);
        line_bad = de_fall && ((pix_cnt_q != ref_ha_q) || (pix_cnt_q == CMAX));
        res_ok   = (h_active_d == COORDSPC'(HRES)) && (v_active_d == COORDSPC'(VRES));
        lock_hit = (32'(match_cnt_q) + 32'd1) >= LOCK_FRAMES;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            {hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_p_q} <= '0;
            pix_cnt_q     <= '0;
            hclk_q        <= '0;
            hs_cnt_q      <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            h_active_q    <= '0;
            h_total_q     <= '0;
            v_active_q    <= '0;
            v_total_q     <= '0;
            seen_rise_q   <= 1'b0;
            fs_pend_q     <= 1'b0;
            de_out_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            {hs_q, vs_q, de_q} <= {hs_d, vs_d, de_d};
            {hs_p_q, vs_p_q, de_p_q} <= {hs_q, vs_q, de_q};
            pix_cnt_q     <= pix_cnt_d;
            hclk_q        <= hclk_d;
            hs_cnt_q      <= hs_cnt_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            h_active_q    <= h_active_d;
            h_total_q     <= h_total_d;
            v_active_q    <= v_active_d;
            v_total_q     <= v_total_d;
            seen_rise_q   <= seen_rise_d;
            fs_pend_q     <= fs_pend_d;
            de_out_q      <= de_out_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    // Lock FSM: compares each completed frame against the captured reference set.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SEARCH;
            match_cnt_q <= '0;
            ref_ha_q    <= '0;
            ref_ht_q    <= '0;
            ref_va_q    <= '0;
            ref_vt_q    <= '0;
            locked_q    <= 1'b0;
            res_match_q <= 1'b0;
`ifdef VIDEO_DETECT_ERRCNT_EN
            err_cnt_q   <= '0;
`endif
        end else if (timeout) begin
            state_q     <= S_SEARCH;
            locked_q    <= 1'b0;
            res_match_q <= 1'b0;
`ifdef VIDEO_DETECT_ERRCNT_EN
            if (state_q == S_LOCKED && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
`endif
        end else begin
            case (state_q)
                S_SEARCH: if (vs_edge) state_q <= S_MEASURE;
                S_MEASURE: if (vs_edge) begin
                    state_q     <= S_CHECK;
                    match_cnt_q <= MW'(1);
                    ref_ha_q    <= h_active_d;
                    ref_ht_q    <= h_total_d;
                    ref_va_q    <= v_active_d;
                    ref_vt_q    <= v_total_d;
                end
                S_CHECK: if (vs_edge) begin
                    if (frame_eq) begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                        if (lock_hit) begin
                            state_q     <= S_LOCKED;
                            locked_q    <= 1'b1;
                            res_match_q <= res_ok;
                        end
                    end else begin
                        match_cnt_q <= MW'(1);
                        ref_ha_q    <= h_active_d;
                        ref_ht_q    <= h_total_d;
                        ref_va_q    <= v_active_d;
                        ref_vt_q    <= v_total_d;
                    end
                end
                S_LOCKED: if (line_bad || (vs_edge && !frame_eq)) begin
                    state_q     <= S_MEASURE;
                    locked_q    <= 1'b0;
                    res_match_q <= 1'b0;
`ifdef VIDEO_DETECT_ERRCNT_EN
                    if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
`endif
                end else begin
                    res_match_q <= res_ok;
                end
                default: state_q <= S_SEARCH;
            endcase
        end
    end

    assign de_out      = de_out_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign h_active    = h_active_q;
    assign h_total     = h_total_q;
    assign v_active    = v_active_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign res_match   = res_match_q;
`ifdef VIDEO_DETECT_ERRCNT_EN
    assign err_count   = err_cnt_q;
`endif
endmodule
